// File: rtl/vdp_cpu_port_pkg.sv
// vdp_cpu_port_pkg: definitions shared by the VDP CPU port and the display pipeline.
//   ADDR_W_DEF / NREGS_DEF : default VRAM address width and register count
//   latch_e                : control-port two-byte latch states
//   ctrl_cmd_e             : meaning of the second control byte
//   STATUS_F_BIT           : bit of the status byte that carries the vsync flag
//   IE_REG / IE_BIT        : register and bit holding the interrupt enable
package vdp_cpu_port_pkg;

  localparam int ADDR_W_DEF   = 14;
  localparam int NREGS_DEF    = 8;
  localparam int STATUS_F_BIT = 7;
  localparam int IE_REG       = 1;
  localparam int IE_BIT       = 5;

  typedef enum logic {
    LATCH_FIRST  = 1'b0,
    LATCH_SECOND = 1'b1
  } latch_e;

  typedef enum logic [1:0] {
    CMD_READ_SETUP  = 2'd0,
    CMD_WRITE_SETUP = 2'd1,
    CMD_REG_WRITE   = 2'd2
  } ctrl_cmd_e;

  // Second control byte: bit7 selects a register write, else bit6 selects write vs read setup.
  function automatic ctrl_cmd_e decode_ctrl(input logic [7:0] b);
    ctrl_cmd_e c;
    if (b[7]) begin
      c = CMD_REG_WRITE;
    end else if (b[6]) begin
      c = CMD_WRITE_SETUP;
    end else begin
      c = CMD_READ_SETUP;
    end
    return c;
  endfunction

endpackage

// File: rtl/vdp_cpu_port_if.sv
// vdp_cpu_port_if: CPU strobe bus plus VRAM access port of the VDP CPU port.
//   cpu_wr/cpu_rd/cpu_mode/cpu_wdata : one-cycle strobes from the bus glue (pxclk domain)
//   cpu_rdata                        : read data returned to the CPU
//   vram_we/vram_re/vram_addr/vram_wdata : VRAM access requests
//   vram_rdata                       : registered VRAM read data (one cycle after vram_re)
// slave  : the VDP CPU port.  master : bus glue plus VRAM.
interface vdp_cpu_port_if #(
  parameter int ADDR_W = 14
) ();
  logic              cpu_wr;
  logic              cpu_rd;
  logic              cpu_mode;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              vram_we;
  logic              vram_re;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic [7:0]        vram_rdata;

  modport slave (
    input  cpu_wr, cpu_rd, cpu_mode, cpu_wdata, vram_rdata,
    output cpu_rdata, vram_we, vram_re, vram_addr, vram_wdata
  );

  modport master (
    output cpu_wr, cpu_rd, cpu_mode, cpu_wdata, vram_rdata,
    input  cpu_rdata, vram_we, vram_re, vram_addr, vram_wdata
  );
endinterface

// File: rtl/vdp_cpu_port_status.sv
// vdp_cpu_port_status: vsync rising-edge detect, status flag F and interrupt output.
//   pxclk, reset_n : clock, asynchronous active-low reset
//   vsync_in       : active-high vsync from the sync generator
//   clr_f          : status-port read strobe, clears F
//   int_en         : interrupt enable (reg1 bit 5)
//   f              : current flag (pre-edge value during a coincident status read)
//   int_n          : active-low interrupt, registered one cycle after F / enable
module vdp_cpu_port_status (
  input  logic pxclk,
  input  logic reset_n,
  input  logic vsync_in,
  input  logic clr_f,
  input  logic int_en,
  output logic f,
  output logic int_n
);

  logic vsync_q, vsync_d;
  logic f_q, f_d;
  logic int_n_q, int_n_d;

  // Next-state: a vsync rising edge sets F even when a status read clears it in the same cycle.
  always_comb begin
    vsync_d = vsync_in;
    f_d     = (vsync_in & ~vsync_q) | (f_q & ~clr_f);
    int_n_d = ~(f_q & int_en);
  end

  // State registers.
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      f_q     <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      vsync_q <= vsync_d;
      f_q     <= f_d;
      int_n_q <= int_n_d;
    end
  end

  assign f     = f_q;
  assign int_n = int_n_q;

endmodule

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: TMS9918-style CPU port into VDP VRAM and registers.
//   pxclk, reset_n : sole clock, asynchronous active-low reset
//   bus (slave)    : CPU strobes (mode 0 = data port, 1 = control port) and VRAM port
//   vsync_in       : vsync, rising edge sets the status flag
//   regs_flat      : register file, reg n at [8n+7:8n]
//   int_n          : active-low interrupt
// Optional feature macro VDP_READAHEAD_EN: read-ahead buffer so data-port reads return
// VRAM contents. Without it vram_re is 0 and data-port reads return 8'hFF.
module vdp_cpu_port
  import vdp_cpu_port_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic               pxclk,
  input  logic               reset_n,
  vdp_cpu_port_if.slave      bus,
  input  logic               vsync_in,
  output logic [8*NREGS-1:0] regs_flat,
  output logic               int_n
);

  latch_e            latch_q, latch_d;
  logic [7:0]        tmp_q, tmp_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        regs_q [NREGS];
  logic [7:0]        regs_d [NREGS];
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]        vram_wdata_q, vram_wdata_d;
  logic [7:0]        status_s;
  logic [13:0]       ctrl_addr_s;
  logic              f_s;
  logic              data_wr_s, ctrl_wr_s, data_rd_s, stat_rd_s;
`ifdef VDP_READAHEAD_EN
  logic              vram_re_q, vram_re_d;
  logic              ra_wait_q, ra_wait_d;
  logic [7:0]        rbuf_q, rbuf_d;
`else
  logic              unused_rdata_s;
  assign unused_rdata_s = ^bus.vram_rdata;
`endif

  assign data_wr_s = bus.cpu_wr & ~bus.cpu_mode;
  assign ctrl_wr_s = bus.cpu_wr &  bus.cpu_mode;
  assign data_rd_s = bus.cpu_rd & ~bus.cpu_mode;
  assign stat_rd_s = bus.cpu_rd &  bus.cpu_mode;

  vdp_cpu_port_status u_status (
    .pxclk    (pxclk),
    .reset_n  (reset_n),
    .vsync_in (vsync_in),
    .clr_f    (stat_rd_s),
    .int_en   (regs_q[IE_REG][IE_BIT]),
    .f        (f_s),
    .int_n    (int_n)
  );

  // Next-state for pointer, latch, registers, read buffer and registered VRAM/CPU outputs.
  always_comb begin
    latch_d      = latch_q;
    tmp_d        = tmp_q;
    ptr_d        = ptr_q;
    regs_d       = regs_q;
    cpu_rdata_d  = cpu_rdata_q;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    status_s     = 8'h00;
    status_s[STATUS_F_BIT] = f_s;
    ctrl_addr_s  = {bus.cpu_wdata[5:0], tmp_q};
`ifdef VDP_READAHEAD_EN
    vram_re_d = 1'b0;
    rbuf_d    = rbuf_q;
    ra_wait_d = vram_re_q;
    // Read data arrives the cycle after vram_re; a data write in that cycle overrides it below.
    if (ra_wait_q) begin
      rbuf_d = bus.vram_rdata;
      ptr_d  = ptr_q + ADDR_W'(1);
    end else begin
      rbuf_d = rbuf_q;
    end
`endif
    if (data_wr_s) begin
      vram_we_d    = 1'b1;
      vram_addr_d  = ptr_q;
      vram_wdata_d = bus.cpu_wdata;
      ptr_d        = ptr_q + ADDR_W'(1);
      latch_d      = LATCH_FIRST;
`ifdef VDP_READAHEAD_EN
      rbuf_d       = bus.cpu_wdata;
`endif
    end else if (data_rd_s) begin
      latch_d = LATCH_FIRST;
`ifdef VDP_READAHEAD_EN
      cpu_rdata_d = rbuf_q;
      vram_re_d   = 1'b1;
      vram_addr_d = ptr_q;
`else
      cpu_rdata_d = 8'hFF;
      ptr_d       = ptr_q + ADDR_W'(1);
`endif
    end else if (stat_rd_s) begin
      cpu_rdata_d = status_s;
      latch_d     = LATCH_FIRST;
    end else if (ctrl_wr_s) begin
      if (latch_q == LATCH_FIRST) begin
        tmp_d   = bus.cpu_wdata;
        latch_d = LATCH_SECOND;
      end else begin
        latch_d = LATCH_FIRST;
        case (decode_ctrl(bus.cpu_wdata))
          CMD_REG_WRITE: begin
            if (int'(bus.cpu_wdata[2:0]) < NREGS) begin
              regs_d[bus.cpu_wdata[2:0]] = tmp_q;
            end else begin
              regs_d = regs_q;
            end
          end
          CMD_WRITE_SETUP: ptr_d = ADDR_W'(ctrl_addr_s);
          CMD_READ_SETUP: begin
            ptr_d = ADDR_W'(ctrl_addr_s);
`ifdef VDP_READAHEAD_EN
            vram_re_d   = 1'b1;
            vram_addr_d = ADDR_W'(ctrl_addr_s);
`endif
          end
          default: latch_d = LATCH_FIRST;
        endcase
      end
    end else begin
      latch_d = latch_q;
    end
  end

  // State and output registers.
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q      <= LATCH_FIRST;
      tmp_q        <= 8'h00;
      ptr_q        <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= 8'h00;
`ifdef VDP_READAHEAD_EN
      vram_re_q    <= 1'b0;
      ra_wait_q    <= 1'b0;
      rbuf_q       <= 8'h00;
`endif
    end else begin
      latch_q      <= latch_d;
      tmp_q        <= tmp_d;
      ptr_q        <= ptr_d;
      regs_q       <= regs_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
`ifdef VDP_READAHEAD_EN
      vram_re_q    <= vram_re_d;
      ra_wait_q    <= ra_wait_d;
      rbuf_q       <= rbuf_d;
`endif
    end
  end

  // Flatten the register file for the display pipeline.
  always_comb begin
    regs_flat = {(8*NREGS){1'b0}};
    for (int i = 0; i < NREGS; i++) regs_flat[8*i +: 8] = regs_q[i];
  end

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vram_we    = vram_we_q;
  assign bus.vram_addr  = vram_addr_q;
  assign bus.vram_wdata = vram_wdata_q;
`ifdef VDP_READAHEAD_EN
  assign bus.vram_re    = vram_re_q;
`else
  assign bus.vram_re    = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: randomized bench for vdp_cpu_port with a transaction-level model.
// Stimulus ops are spaced five cycles apart, as the bus glue guarantees.
module tb_vdp_cpu_port;
  localparam int AW = 14;
  localparam int NR = 8;
  localparam int K_WE = 0, K_RE = 1, K_RDATA = 2, K_REG = 3, K_F = 4;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
  } ev_t;

  logic            pxclk = 1'b0;
  logic            reset_n;
  logic            vsync_in;
  logic [8*NR-1:0] regs_flat;
  logic            int_n;

  vdp_cpu_port_if #(.ADDR_W(AW)) bus ();

  vdp_cpu_port #(.ADDR_W(AW), .NREGS(NR)) dut (
    .pxclk     (pxclk),
    .reset_n   (reset_n),
    .bus       (bus),
    .vsync_in  (vsync_in),
    .regs_flat (regs_flat),
    .int_n     (int_n)
  );

  always #5 pxclk = ~pxclk;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge pxclk) cyc <= cyc + 1;

  // VRAM emulator: unwritten locations read back a fixed address-derived pattern.
  logic [7:0] vram [2**AW];
  bit         vram_v [2**AW];
  function automatic logic [7:0] fill(input logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction
  always @(posedge pxclk) begin
    if (bus.vram_re) bus.vram_rdata <= vram_v[bus.vram_addr] ? vram[bus.vram_addr] : fill(bus.vram_addr);
    if (bus.vram_we) begin
      vram[bus.vram_addr]   <= bus.vram_wdata;
      vram_v[bus.vram_addr] <= 1'b1;
    end
  end

  // Transaction-level model state.
  logic [AW-1:0] m_ptr;
  bit            m_second;
  logic [7:0]    m_tmp, m_buf;
  logic [7:0]    m_regs [NR];
  bit            m_f;
  logic [7:0]    m_mem [2**AW];
  bit            m_v [2**AW];
  // Expected observable state, advanced by scheduled events.
  ev_t           sched[$];
  logic [7:0]    e_rdata;
  logic [7:0]    e_regs [NR];
  bit            e_f;

  function automatic logic [7:0] m_rd(input logic [AW-1:0] a);
    return m_v[a] ? m_mem[a] : fill(a);
  endfunction

  task automatic push(input int kind, input int idx, input logic [31:0] val);
    ev_t e;
    e.cyc = cyc + 1; e.kind = kind; e.idx = idx; e.val = val;
    sched.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_ptr = '0; m_second = 1'b0; m_tmp = 8'h00; m_buf = 8'h00; m_f = 1'b0;
    for (int i = 0; i < NR; i++) begin m_regs[i] = 8'h00; e_regs[i] = 8'h00; end
    e_rdata = 8'h00; e_f = 1'b0;
    sched.delete();
  endtask

  // Per-cycle comparison against the model.
  always @(negedge pxclk) begin
    ev_t             e;
    bit              we_e, re_e;
    logic [AW-1:0]   a_e;
    logic [7:0]      d_e;
    logic            int_n_e;
    logic [8*NR-1:0] flat_e;
    int_n_e = ~(e_f & e_regs[1][5]);
    we_e = 1'b0; re_e = 1'b0; a_e = '0; d_e = 8'h00;
    while (sched.size() > 0 && sched[0].cyc <= cyc) begin
      e = sched.pop_front();
      case (e.kind)
        K_WE:    begin we_e = 1'b1; a_e = e.val[21:8]; d_e = e.val[7:0]; end
        K_RE:    begin re_e = 1'b1; a_e = e.val[21:8]; end
        K_RDATA: e_rdata = e.val[7:0];
        K_REG:   e_regs[e.idx] = e.val[7:0];
        K_F:     e_f = e.val[0];
        default: ;
      endcase
    end
    for (int i = 0; i < NR; i++) flat_e[8*i +: 8] = e_regs[i];
    chk("vram_we", 64'(bus.vram_we), 64'(we_e));
    chk("vram_re", 64'(bus.vram_re), 64'(re_e));
    if (we_e) begin
      chk("wr_addr", 64'(bus.vram_addr), 64'(a_e));
      chk("wr_data", 64'(bus.vram_wdata), 64'(d_e));
    end
    if (re_e) chk("rd_addr", 64'(bus.vram_addr), 64'(a_e));
    chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e_rdata));
    chk("regs_flat", 64'(regs_flat), 64'(flat_e));
    chk("int_n", 64'(int_n), 64'(int_n_e));
  end

  task automatic gap();
    repeat (4) @(posedge pxclk);
    #1;
  endtask

  task automatic strobe_end();
    @(posedge pxclk);
    #1;
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] d);
    gap();
    bus.cpu_mode = 1'b0; bus.cpu_wdata = d; bus.cpu_wr = 1'b1;
    push(K_WE, 0, {10'h000, m_ptr, d});
    m_mem[m_ptr] = d; m_v[m_ptr] = 1'b1;
    m_buf = d; m_ptr = m_ptr + 14'd1; m_second = 1'b0;
    strobe_end();
  endtask

  task automatic data_rd();
    gap();
    bus.cpu_mode = 1'b0; bus.cpu_rd = 1'b1;
`ifdef VDP_READAHEAD_EN
    push(K_RDATA, 0, {24'h000000, m_buf});
    push(K_RE, 0, {10'h000, m_ptr, 8'h00});
    m_buf = m_rd(m_ptr);
`else
    push(K_RDATA, 0, 32'h000000FF);
`endif
    m_ptr = m_ptr + 14'd1; m_second = 1'b0;
    strobe_end();
  endtask

  task automatic status_rd(input bit with_vsync);
    gap();
    bus.cpu_mode = 1'b1; bus.cpu_rd = 1'b1; vsync_in = with_vsync;
    push(K_RDATA, 0, {24'h000000, m_f, 7'h00});
    m_f = with_vsync;
    push(K_F, 0, {31'h0, m_f});
    m_second = 1'b0;
    strobe_end();
  endtask

  task automatic vsync_pulse();
    gap();
    vsync_in = 1'b1;
    m_f = 1'b1;
    push(K_F, 0, 32'h1);
    strobe_end();
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    gap();
    bus.cpu_mode = 1'b1; bus.cpu_wdata = d; bus.cpu_wr = 1'b1;
    if (!m_second) begin
      m_tmp = d; m_second = 1'b1;
    end else begin
      m_second = 1'b0;
      if (d[7]) begin
        m_regs[d[2:0]] = m_tmp;
        push(K_REG, int'(d[2:0]), {24'h000000, m_tmp});
      end else begin
        m_ptr = {d[5:0], m_tmp};
`ifdef VDP_READAHEAD_EN
        if (!d[6]) begin
          push(K_RE, 0, {10'h000, m_ptr, 8'h00});
          m_buf = m_rd(m_ptr);
          m_ptr = m_ptr + 14'd1;
        end
`endif
      end
    end
    strobe_end();
  endtask

  task automatic do_reset();
    @(posedge pxclk);
    #1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge pxclk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bit   with_v;
    logic [7:0] expect_rd;
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_mode = 1'b0; bus.cpu_wdata = 8'h00;
    vsync_in = 1'b0; reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge pxclk);
    #1;
    reset_n = 1'b1;

    // Write setup at 0x0000, two data writes.
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(8'hAA);
    chk("t1_addr0", 64'(bus.vram_addr), 64'(14'h0000));
    chk("t1_data0", 64'(bus.vram_wdata), 64'(8'hAA));
    data_wr(8'h55);
    chk("t1_addr1", 64'(bus.vram_addr), 64'(14'h0001));
    chk("t1_data1", 64'(bus.vram_wdata), 64'(8'h55));
    chk("t1_model_ptr", 64'(m_ptr), 64'(14'h0002));

    // Register write leaves the pointer alone.
    ctrl_wr(8'h07); ctrl_wr(8'h81);
    chk("t2_reg1", 64'(regs_flat[15:8]), 64'(8'h07));
    chk("t2_no_we", 64'(bus.vram_we), 64'(1'b0));
    data_wr(8'h11);
    chk("t2_addr", 64'(bus.vram_addr), 64'(14'h0002));

    // Pointer wrap.
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    data_wr(8'h01);
    chk("t3_addr_top", 64'(bus.vram_addr), 64'(14'h3FFF));
    data_wr(8'h02);
    chk("t3_addr_wrap", 64'(bus.vram_addr), 64'(14'h0000));

    // Preload 0x0100/0x0101, read setup, two data reads.
    ctrl_wr(8'h00); ctrl_wr(8'h41);
    data_wr(8'h12); data_wr(8'h34);
    ctrl_wr(8'h00); ctrl_wr(8'h01);
`ifdef VDP_READAHEAD_EN
    expect_rd = 8'h12;
`else
    expect_rd = 8'hFF;
`endif
    data_rd();
    chk("t4_read0", 64'(bus.cpu_rdata), 64'(expect_rd));
`ifdef VDP_READAHEAD_EN
    expect_rd = 8'h34;
`endif
    data_rd();
    chk("t4_read1", 64'(bus.cpu_rdata), 64'(expect_rd));

    // Interrupt enable, vsync, status read.
    ctrl_wr(8'h20); ctrl_wr(8'h81);
    chk("t5_model_reg1", 64'(m_regs[1]), 64'(8'h20));
    vsync_pulse();
    @(posedge pxclk);
    #1;
    chk("t5_int_low", 64'(int_n), 64'(1'b0));
    status_rd(1'b0);
    chk("t5_status_set", 64'(bus.cpu_rdata), 64'(8'h80));
    @(posedge pxclk);
    #1;
    chk("t5_int_high", 64'(int_n), 64'(1'b1));
    status_rd(1'b0);
    chk("t5_status_clr", 64'(bus.cpu_rdata), 64'(8'h00));
    status_rd(1'b1);
    chk("t5_coincident_pre", 64'(bus.cpu_rdata), 64'(8'h00));
    status_rd(1'b0);
    chk("t5_coincident_set", 64'(bus.cpu_rdata), 64'(8'h80));

    // Status read resets the control latch.
    ctrl_wr(8'h34);
    status_rd(1'b0);
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(8'h5A);
    chk("t6_addr", 64'(bus.vram_addr), 64'(14'h0000));
    chk("t6_model_ptr", 64'(m_ptr), 64'(14'h0001));

    // Reset in the middle of a control pair.
    ctrl_wr(8'h12);
    do_reset();
    chk("t7_regs_zero", 64'(regs_flat), 64'(64'h0));
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(8'h77);
    chk("t7_addr", 64'(bus.vram_addr), 64'(14'h0000));

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        data_wr(8'($urandom));
      end else if (r <= 4) begin
        data_rd();
      end else if (r == 5) begin
        with_v = ($urandom_range(0, 3) == 0);
        status_rd(with_v);
      end else if (r <= 8) begin
        if (m_second) begin
          case ($urandom_range(0, 2))
            0:       ctrl_wr(8'h80 | 8'($urandom_range(0, 127)));
            1:       ctrl_wr(8'h40 | 8'($urandom_range(0, 63)));
            default: ctrl_wr(8'($urandom_range(0, 63)));
          endcase
        end else begin
          ctrl_wr(8'($urandom));
        end
      end else begin
        vsync_pulse();
      end
    end

    repeat (6) @(posedge pxclk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
